// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded ARM control and operand fields for the EX stage.
// Latency 1 cycle; freeze holds the contents, flush (which beats freeze) loads a bubble.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CMD_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              validIn,
    input  logic [DATA_W-1:0] pcIn,
    input  logic [DATA_W-1:0] valRnIn,
    input  logic [DATA_W-1:0] valRmIn,
    input  logic [CMD_W-1:0]  exeCmdIn,
    input  logic              memReadIn,
    input  logic              memWriteIn,
    input  logic              wbEnIn,
    input  logic              branchIn,
    input  logic              sBitIn,
    input  logic              immIn,
    input  logic [11:0]       shiftOperandIn,
    input  logic [23:0]       signedImm24In,
    input  logic [REG_AW-1:0] destIn,
    input  logic [REG_AW-1:0] src1In,
    input  logic [REG_AW-1:0] src2In,
    input  logic [3:0]        statusIn,
    output logic              validOut,
    output logic [DATA_W-1:0] pcOut,
    output logic [DATA_W-1:0] valRnOut,
    output logic [DATA_W-1:0] valRmOut,
    output logic [CMD_W-1:0]  exeCmdOut,
    output logic              memReadOut,
    output logic              memWriteOut,
    output logic              wbEnOut,
    output logic              branchOut,
    output logic              sBitOut,
    output logic              immOut,
    output logic [11:0]       shiftOperandOut,
    output logic [23:0]       signedImm24Out,
    output logic [REG_AW-1:0] destOut,
    output logic [REG_AW-1:0] src1Out,
    output logic [REG_AW-1:0] src2Out,
    output logic [3:0]        statusOut,
    output logic              isMemOut
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            // Reset and flush both produce an all-zero bubble
            validOut        <= 1'b0;
            pcOut           <= '0;
            valRnOut        <= '0;
            valRmOut        <= '0;
            exeCmdOut       <= '0;
            memReadOut      <= 1'b0;
            memWriteOut     <= 1'b0;
            wbEnOut         <= 1'b0;
            branchOut       <= 1'b0;
            sBitOut         <= 1'b0;
            immOut          <= 1'b0;
            shiftOperandOut <= '0;
            signedImm24Out  <= '0;
            destOut         <= '0;
            src1Out         <= '0;
            src2Out         <= '0;
            statusOut       <= '0;
            isMemOut        <= 1'b0;
        end else if (!freeze) begin
            validOut        <= validIn;
            pcOut           <= pcIn;
            valRnOut        <= valRnIn;
            valRmOut        <= valRmIn;
            exeCmdOut       <= exeCmdIn;
            // Side-effecting controls are gated so a non-valid slot can never act
            memReadOut      <= memReadIn & validIn;
            memWriteOut     <= memWriteIn & validIn;
            wbEnOut         <= wbEnIn & validIn;
            branchOut       <= branchIn & validIn;
            sBitOut         <= sBitIn & validIn;
            immOut          <= immIn;
            shiftOperandOut <= shiftOperandIn;
            signedImm24Out  <= signedImm24In;
            destOut         <= destIn;
            src1Out         <= src1In;
            src2Out         <= src2In;
            statusOut       <= statusIn;
            isMemOut        <= (memReadIn | memWriteIn) & validIn;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed test-plan cases plus randomized traffic vs a reference model.
module tb_id_ex_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze, flush, validIn;
    logic [31:0] pcIn, valRnIn, valRmIn;
    logic [3:0]  exeCmdIn;
    logic        memReadIn, memWriteIn, wbEnIn, branchIn, sBitIn, immIn;
    logic [11:0] shiftOperandIn;
    logic [23:0] signedImm24In;
    logic [3:0]  destIn, src1In, src2In, statusIn;

    logic        validOut;
    logic [31:0] pcOut, valRnOut, valRmOut;
    logic [3:0]  exeCmdOut;
    logic        memReadOut, memWriteOut, wbEnOut, branchOut, sBitOut, immOut, isMemOut;
    logic [11:0] shiftOperandOut;
    logic [23:0] signedImm24Out;
    logic [3:0]  destOut, src1Out, src2Out, statusOut;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.DATA_W(32), .REG_AW(4), .CMD_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .validIn(validIn),
        .pcIn(pcIn), .valRnIn(valRnIn), .valRmIn(valRmIn), .exeCmdIn(exeCmdIn),
        .memReadIn(memReadIn), .memWriteIn(memWriteIn), .wbEnIn(wbEnIn),
        .branchIn(branchIn), .sBitIn(sBitIn), .immIn(immIn),
        .shiftOperandIn(shiftOperandIn), .signedImm24In(signedImm24In),
        .destIn(destIn), .src1In(src1In), .src2In(src2In), .statusIn(statusIn),
        .validOut(validOut), .pcOut(pcOut), .valRnOut(valRnOut), .valRmOut(valRmOut),
        .exeCmdOut(exeCmdOut), .memReadOut(memReadOut), .memWriteOut(memWriteOut),
        .wbEnOut(wbEnOut), .branchOut(branchOut), .sBitOut(sBitOut), .immOut(immOut),
        .shiftOperandOut(shiftOperandOut), .signedImm24Out(signedImm24Out),
        .destOut(destOut), .src1Out(src1Out), .src2Out(src2Out), .statusOut(statusOut),
        .isMemOut(isMemOut)
    );

    // Expected contents of the stage register, as an instruction record
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rn, rm;
        logic [3:0]  cmd;
        logic        mr, mw, wb, br, sb, imm, ismem;
        logic [11:0] sh;
        logic [23:0] off;
        logic [3:0]  d, s1, s2, st;
    } rec_t;

    rec_t mdl;

    function automatic rec_t model_next(rec_t cur);
        rec_t n;
        if (flush) return '0;
        if (freeze) return cur;
        n.valid = validIn;
        n.pc = pcIn; n.rn = valRnIn; n.rm = valRmIn; n.cmd = exeCmdIn;
        n.mr = validIn ? memReadIn : 1'b0;
        n.mw = validIn ? memWriteIn : 1'b0;
        n.wb = validIn ? wbEnIn : 1'b0;
        n.br = validIn ? branchIn : 1'b0;
        n.sb = validIn ? sBitIn : 1'b0;
        n.ismem = validIn && (memReadIn || memWriteIn);
        n.imm = immIn;
        n.sh = shiftOperandIn; n.off = signedImm24In;
        n.d = destIn; n.s1 = src1In; n.s2 = src2In; n.st = statusIn;
        return n;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".valid"}, 64'(validOut), 64'(mdl.valid));
        check_val({tag, ".pc"}, 64'(pcOut), 64'(mdl.pc));
        check_val({tag, ".valRn"}, 64'(valRnOut), 64'(mdl.rn));
        check_val({tag, ".valRm"}, 64'(valRmOut), 64'(mdl.rm));
        check_val({tag, ".exeCmd"}, 64'(exeCmdOut), 64'(mdl.cmd));
        check_val({tag, ".ctrl"},
                  64'({memReadOut, memWriteOut, wbEnOut, branchOut, sBitOut, immOut, isMemOut}),
                  64'({mdl.mr, mdl.mw, mdl.wb, mdl.br, mdl.sb, mdl.imm, mdl.ismem}));
        check_val({tag, ".shift"}, 64'(shiftOperandOut), 64'(mdl.sh));
        check_val({tag, ".imm24"}, 64'(signedImm24Out), 64'(mdl.off));
        check_val({tag, ".regs"}, 64'({destOut, src1Out, src2Out, statusOut}),
                  64'({mdl.d, mdl.s1, mdl.s2, mdl.st}));
    endtask

    // One rising edge: advance the model with the inputs held across it, then sample
    task automatic step(input string tag);
        @(posedge clk);
        mdl = model_next(mdl);
        #1;
        compare_all(tag);
    endtask

    task automatic drive_random();
        validIn        = ($urandom_range(0, 3) != 0);
        pcIn           = $urandom; valRnIn = $urandom; valRmIn = $urandom;
        exeCmdIn       = 4'($urandom);
        memReadIn      = 1'($urandom); memWriteIn = 1'($urandom);
        wbEnIn         = 1'($urandom); branchIn   = 1'($urandom);
        sBitIn         = 1'($urandom);
        immIn          = validIn ? 1'($urandom) : 1'b0;
        shiftOperandIn = 12'($urandom); signedImm24In = 24'($urandom);
        destIn = 4'($urandom); src1In = 4'($urandom); src2In = 4'($urandom);
        statusIn = 4'($urandom);
    endtask

    task automatic clear_inputs();
        freeze = 0; flush = 0; validIn = 0;
        pcIn = 0; valRnIn = 0; valRmIn = 0; exeCmdIn = 0;
        memReadIn = 0; memWriteIn = 0; wbEnIn = 0; branchIn = 0; sBitIn = 0; immIn = 0;
        shiftOperandIn = 0; signedImm24In = 0;
        destIn = 0; src1In = 0; src2In = 0; statusIn = 0;
    endtask

    initial begin
        clear_inputs();
        mdl = '0;
        rst_n = 1'b0;
        #1;
        compare_all("reset_init");
        #20;
        rst_n = 1'b1;

        // Load a non-zero instruction, then reset mid-cycle with all inputs non-zero
        drive_random();
        validIn = 1; immIn = 1;
        memReadIn = 1; wbEnIn = 1;
        step("preload");
        #2;
        rst_n = 1'b0;
        mdl = '0;
        #1;
        compare_all("reset_async");
        check_val("reset_async.pc", 64'(pcOut), 64'h0);
        #1;
        rst_n = 1'b1;
        clear_inputs();
        pcIn = 32'h0000_0008; validIn = 1;
        step("after_reset");
        check_val("after_reset.pc", 64'(pcOut), 64'h8);
        check_val("after_reset.valid", 64'(validOut), 64'h1);

        // Pass-through
        clear_inputs();
        validIn = 1; valRmIn = 32'hF000_000F; shiftOperandIn = 12'h0E3;
        memReadIn = 1; wbEnIn = 1; destIn = 4'h3;
        step("pass");
        check_val("pass.valRm", 64'(valRmOut), 64'hF000_000F);
        check_val("pass.isMem", 64'(isMemOut), 64'h1);
        check_val("pass.dest", 64'(destOut), 64'h3);

        // Freeze for three edges
        clear_inputs();
        validIn = 1; pcIn = 32'h10;
        step("frz_cap");
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            pcIn = 32'h14 + 32'(4 * i);
            step("frz_hold");
            check_val("frz_hold.pc", 64'(pcOut), 64'h10);
        end
        freeze = 0;
        step("frz_release");
        check_val("frz_release.pc", 64'(pcOut), 64'h1C);

        // Flush after a writing instruction
        clear_inputs();
        validIn = 1; wbEnIn = 1; memWriteIn = 1; pcIn = 32'h40;
        step("fl_cap");
        flush = 1;
        step("flush");
        check_val("flush.ctrl", 64'({validOut, wbEnOut, memWriteOut, isMemOut}), 64'h0);
        check_val("flush.pc", 64'(pcOut), 64'h0);

        // Flush beats freeze
        clear_inputs();
        validIn = 1; wbEnIn = 1; branchIn = 1; sBitIn = 1; pcIn = 32'h80;
        step("ff_cap");
        freeze = 1; flush = 1;
        step("flush_freeze");
        check_val("flush_freeze.valid", 64'(validOut), 64'h0);
        check_val("flush_freeze.ctrl", 64'({wbEnOut, branchOut, sBitOut}), 64'h0);

        // Masking of controls on a non-valid slot
        clear_inputs();
        validIn = 0; wbEnIn = 1; branchIn = 1; memReadIn = 1; pcIn = 32'hC0;
        step("mask");
        check_val("mask.ctrl", 64'({validOut, wbEnOut, branchOut, isMemOut}), 64'h0);

        // Randomized traffic with freeze, flush and occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            drive_random();
            freeze = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 9) == 0);
            step("rand");
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst_n = 1'b0;
                mdl = '0;
                #1;
                compare_all("rand_rst");
                #1;
                rst_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between the ARM Instruction Decode stage and the Execute stage.
- Captures decoded control and operand fields each cycle and presents them registered to the EX-stage value generator (valRm, imm, isMem, shiftOperand), the ALU and the branch adder.
- Supports hazard freeze (hold) and branch flush (bubble insertion).
- Carries a valid bit so downstream stages can tell real instructions from bubbles.

Parameters:
- DATA_W, 32, width of PC and register operand values
- REG_AW, 4, register-file address width (dest, src1, src2)
- CMD_W, 4, ALU execute-command width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- freeze  input  1  hold all outputs (hazard stall)
- flush  input  1  replace captured instruction with a bubble (branch taken)
- validIn  input  1  ID stage holds a real instruction
- pcIn  input  DATA_W  PC+4 of the decoded instruction
- valRnIn  input  DATA_W  register-file Rn value
- valRmIn  input  DATA_W  register-file Rm value
- exeCmdIn  input  CMD_W  ALU command
- memReadIn, memWriteIn, wbEnIn, branchIn, sBitIn, immIn  input  1 each  decoded control bits
- shiftOperandIn  input  12  instruction[11:0]
- signedImm24In  input  24  branch offset
- destIn, src1In, src2In  input  REG_AW each  destination and source register addresses
- statusIn  input  4  NZCV flags at decode time
- validOut, pcOut, valRnOut, valRmOut, exeCmdOut, memReadOut, memWriteOut, wbEnOut, branchOut, sBitOut, immOut, shiftOperandOut, signedImm24Out, destOut, src1Out, src2Out, statusOut  output  widths as corresponding inputs  registered copies
- isMemOut  output  1  registered memReadIn|memWriteIn, consumed by the value generator

Behaviour:
- Reset: while rst_n=0, every output is 0 immediately, independent of clk. Reset takes effect mid-cycle and overrides freeze and flush. First capture is on the first rising edge after rst_n deasserts.
- Latency: 1 cycle. On each rising edge, at most one of the following applies, in priority order:
  1. flush=1: bubble. validOut, memReadOut, memWriteOut, wbEnOut, branchOut, sBitOut, immOut and isMemOut become 0. exeCmdOut becomes 0. All data and address fields (pc, valRn, valRm, shiftOperand, signedImm24, dest, src1, src2, status) become 0. Flush beats freeze when both are asserted.
  2. freeze=1, flush=0: every output holds its current value, including validOut.
  3. Otherwise: every output takes its corresponding input. validOut=validIn. isMemOut=memReadIn|memWriteIn.
- A bubble (validOut=0) must never have wbEn, memRead, memWrite, branch or sBit set. This holds by construction through the flush and reset paths.
  - If validIn=0 arrives with control bits set, they are masked: each control output = controlIn & validIn.
  - isMemOut is masked the same way.
- No combinational path from any input to any output. All outputs come from flops.
- Flush across a multi-cycle freeze: the first edge with flush=1 clears the register, then normal or freeze rules resume.
- Freeze with flush=0 across consecutive edges holds the same instruction indefinitely. No internal counter and no timeout.

Test Plan:
- Reset: drive all inputs non-zero, pulse rst_n low between edges -> all outputs 0 before the next edge. Release, one edge with pcIn=0x00000008, validIn=1 -> pcOut=0x00000008, validOut=1.
- Pass-through: valRmIn=0xF000000F, immIn=0, shiftOperandIn=0x0E3, memReadIn=1, wbEnIn=1, destIn=4'h3 -> exactly one edge later: valRmOut=0xF000000F, shiftOperandOut=0x0E3, isMemOut=1, wbEnOut=1, destOut=3.
- Freeze: capture pcIn=0x10, then hold freeze=1 for 3 edges while pcIn changes to 0x14, 0x18, 0x1C -> pcOut stays 0x10. Drop freeze -> next edge pcOut=0x1C.
- Flush: capture wbEnIn=1, memWriteIn=1, validIn=1, then assert flush for one edge -> validOut=0, wbEnOut=0, memWriteOut=0, isMemOut=0, pcOut=0.
- Flush vs freeze: assert freeze=1 and flush=1 together with a valid instruction held -> next edge shows a bubble (validOut=0, all controls 0).
- Masking: validIn=0 with wbEnIn=1, branchIn=1, memReadIn=1 -> after edge validOut=0, wbEnOut=0, branchOut=0, isMemOut=0.
